// File: rtl/pipe_hazard_ctrl_if.sv
// Interface bundling the hazard controller's pipeline-side inputs and its
// stage write-enable / flush outputs.
interface pipe_hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic [4:0] ex_rt;
  logic       ex_mread;
  logic       ex_branch_taken;
  logic       mem_busy;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_write;
  logic       idex_flush;
  logic [1:0] state;
  logic       timeout_err;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_rt, ex_mread, ex_branch_taken, mem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush, state, timeout_err
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_rt, ex_mread, ex_branch_taken, mem_busy,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_flush, state, timeout_err
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Load-use / branch-flush / memory-freeze controller for the 5-stage pipeline.
// Optional HAZ_STATS_EN adds saturating per-action event counters.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned TO_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_hazard_ctrl_if.slave    hz
`ifdef HAZ_STATS_EN
    ,
    output logic [15:0]          lu_stall_cnt,
    output logic [15:0]          br_flush_cnt,
    output logic [15:0]          mem_wait_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        BR_FLUSH = 2'd2,
        MEM_WAIT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [TO_W-1:0]   wait_cnt, wait_nxt;
    logic              err_q;
    logic              load_use;
    logic              act_frz, act_br, act_lu;

    assign load_use = hz.ex_mread && (hz.ex_rt != '0) &&
                      ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));

    // Priority chain: freeze beats branch flush beats load-use bubble.
    assign act_frz = hz.mem_busy;
    assign act_br  = !hz.mem_busy && hz.ex_branch_taken;
    assign act_lu  = !hz.mem_busy && !hz.ex_branch_taken && load_use;

    always_comb begin
        state_d       = RUN;
        hz.pc_write   = 1'b1;
        hz.ifid_write = 1'b1;
        hz.ifid_flush = 1'b0;
        hz.idex_write = 1'b1;
        hz.idex_flush = 1'b0;
        // Outputs are forced to pass-through values while reset is held.
        if (!rst) begin
            if (act_frz) begin
                state_d       = MEM_WAIT;
                hz.pc_write   = 1'b0;
                hz.ifid_write = 1'b0;
                hz.idex_write = 1'b0;
            end else if (act_br) begin
                state_d       = BR_FLUSH;
                hz.ifid_flush = 1'b1;
                hz.idex_flush = 1'b1;
            end else if (act_lu) begin
                state_d       = LU_STALL;
                hz.pc_write   = 1'b0;
                hz.ifid_write = 1'b0;
                hz.idex_flush = 1'b1;
            end
        end
    end

    always_comb begin
        wait_nxt = '0;
        if (hz.mem_busy) begin
            wait_nxt = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= wait_nxt;
            if (hz.mem_busy && (wait_nxt == TO_W'(MEM_TIMEOUT))) begin
                err_q <= 1'b1;
            end
        end
    end

    assign hz.state       = state_q;
    assign hz.timeout_err = err_q;

`ifdef HAZ_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lu_stall_cnt <= '0;
            br_flush_cnt <= '0;
            mem_wait_cnt <= '0;
        end else begin
            if (act_lu && (lu_stall_cnt != '1)) lu_stall_cnt <= lu_stall_cnt + 16'd1;
            if (act_br && (br_flush_cnt != '1)) br_flush_cnt <= br_flush_cnt + 16'd1;
            if (act_frz && (mem_wait_cnt != '1)) mem_wait_cnt <= mem_wait_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a queue of expected per-cycle results.
// Define HAZ_STATS_EN to also check the event counters.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hz ();

`ifdef HAZ_STATS_EN
    logic [15:0] lu_stall_cnt, br_flush_cnt, mem_wait_cnt;
`endif

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .TO_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
`ifdef HAZ_STATS_EN
        ,
        .lu_stall_cnt (lu_stall_cnt),
        .br_flush_cnt (br_flush_cnt),
        .mem_wait_cnt (mem_wait_cnt)
`endif
    );

    // ctrl packing: {pc_write, ifid_write, ifid_flush, idex_write, idex_flush}
    localparam logic [4:0] C_RUN = 5'b11010;
    localparam logic [4:0] C_FRZ = 5'b00000;
    localparam logic [4:0] C_BR  = 5'b11111;
    localparam logic [4:0] C_LU  = 5'b00011;

    typedef struct {
        logic [4:0] ctrl;
        logic [1:0] st;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_asserts = 0;
    int   n_fail    = 0;

    function automatic logic [4:0] ctrl_obs();
        return {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_write, hz.idex_flush};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, queue its expectation, then compare the combinational
    // controls before the edge and the registered state/flag after it.
    task automatic step(input string tag,
                        input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                        input logic [4:0] exrt, input logic mread, input logic br,
                        input logic busy,
                        input logic [4:0] ectrl, input logic [1:0] est, input logic eerr);
        exp_t e;
        hz.id_rs = rs; hz.id_rt = rt; hz.id_uses_rt = uses;
        hz.ex_rt = exrt; hz.ex_mread = mread; hz.ex_branch_taken = br;
        hz.mem_busy = busy;
        sb.push_back('{ctrl: ectrl, st: est, err: eerr});
        #1;
        e = sb.pop_front();
        chk({tag, "_ctrl"}, {11'd0, ctrl_obs()}, {11'd0, e.ctrl});
        @(posedge clk);
        #1;
        chk({tag, "_state"}, {14'd0, hz.state}, {14'd0, e.st});
        chk({tag, "_err"}, {15'd0, hz.timeout_err}, {15'd0, e.err});
    endtask

    initial begin
        hz.id_rs = '0; hz.id_rt = '0; hz.id_uses_rt = 1'b0;
        hz.ex_rt = '0; hz.ex_mread = 1'b0; hz.ex_branch_taken = 1'b1;
        hz.mem_busy = 1'b1;

        // Reset held with hazard inputs active: pass-through controls, RUN.
        step("reset", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, C_RUN, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        step("lu",      5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, C_LU,  2'd1, 1'b0);
        step("lu_done", 5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, C_RUN, 2'd0, 1'b0);
        step("zero",    5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, C_RUN, 2'd0, 1'b0);
        step("rt_off",  5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, C_RUN, 2'd0, 1'b0);
        step("rt_on",   5'd3, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, C_LU,  2'd1, 1'b0);
        step("br_lu",   5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, C_BR,  2'd2, 1'b0);
        step("chain",   5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, C_LU,  2'd1, 1'b0);
        for (int i = 0; i < 3; i++)
            step("frz_br", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, C_FRZ, 2'd3, 1'b0);
        step("br_after",5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_BR,  2'd2, 1'b0);
        step("idle",    5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_RUN, 2'd0, 1'b0);

        // Watchdog at MEM_TIMEOUT=4: flag rises on the 4th busy edge and sticks.
        for (int i = 0; i < 3; i++)
            step("wd_pre", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, C_FRZ, 2'd3, 1'b0);
        step("wd_hit",  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, C_FRZ, 2'd3, 1'b1);
        step("wd_hold", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_RUN, 2'd0, 1'b1);
        step("wd_hold2",5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_RUN, 2'd0, 1'b1);

`ifdef HAZ_STATS_EN
        chk("cnt_lu_a",  lu_stall_cnt, 16'd3);
        chk("cnt_br_a",  br_flush_cnt, 16'd2);
        chk("cnt_mw_a",  mem_wait_cnt, 16'd7);
`endif

        // Reset asserted mid-freeze takes effect without a clock edge.
        hz.mem_busy = 1'b1;
        #1;
        chk("frz_pre_rst", {11'd0, ctrl_obs()}, {11'd0, C_FRZ});
        rst = 1'b1;
        #1;
        chk("rst_ctrl",  {11'd0, ctrl_obs()}, {11'd0, C_RUN});
        chk("rst_state", {14'd0, hz.state}, 16'd0);
        chk("rst_err",   {15'd0, hz.timeout_err}, 16'd0);
`ifdef HAZ_STATS_EN
        chk("rst_cnt_lu", lu_stall_cnt, 16'd0);
        chk("rst_cnt_br", br_flush_cnt, 16'd0);
        chk("rst_cnt_mw", mem_wait_cnt, 16'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        step("s_lu1", 5'd2, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, C_LU,  2'd1, 1'b0);
        step("s_run", 5'd0, 5'd0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, C_RUN, 2'd0, 1'b0);
        step("s_lu2", 5'd9, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, C_LU,  2'd1, 1'b0);
        step("s_br",  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_BR,  2'd2, 1'b0);
        for (int i = 0; i < 3; i++)
            step("s_frz", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, C_FRZ, 2'd3, 1'b0);
        step("s_idle",5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_RUN, 2'd0, 1'b0);
`ifdef HAZ_STATS_EN
        chk("cnt_lu_b",  lu_stall_cnt, 16'd2);
        chk("cnt_br_b",  br_flush_cnt, 16'd1);
        chk("cnt_mw_b",  mem_wait_cnt, 16'd3);
`endif

        chk("sb_empty", 16'(sb.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "time limit");
    end
endmodule
